// File: rtl/spi_transaction_sequencer.sv
// SPI slave transaction sequencer: address byte, then read or write data byte(s), Moore-decoded enables.
// Optional SPI_BURST_EN macro enables multi-byte bursts with address auto-increment.
module spi_transaction_sequencer #(
    parameter int unsigned BYTE_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sClkPosEdge,
    input  logic sClkNegEdge,
    input  logic chipSelectConditioned,
    input  logic readWriteEnable,
    output logic addressWriteEnable,
    output logic SRWriteEnable,
    output logic misoBufferEnable,
    output logic DMWriteEnable,
    output logic addressIncrement,
    output logic busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(BYTE_BITS - 1);

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_COMMIT,
        DONE,
        BURST_NEXT
    } stateType;

    stateType         state, stateNext;
    logic [CNT_W-1:0] edgeCount, edgeCountNext;
    logic             countEdge;
    logic             addressWriteEnableNext;
    logic             SRWriteEnableNext;
    logic             misoBufferEnableNext;
    logic             DMWriteEnableNext;
    logic             busyNext;

`ifdef SPI_BURST_EN
    logic isRead;
    logic addressIncrementNext;
`endif

    // State, edge counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            edgeCount          <= '0;
            addressWriteEnable <= 1'b0;
            SRWriteEnable      <= 1'b0;
            misoBufferEnable   <= 1'b0;
            DMWriteEnable      <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state              <= stateNext;
            edgeCount          <= edgeCountNext;
            addressWriteEnable <= addressWriteEnableNext;
            SRWriteEnable      <= SRWriteEnableNext;
            misoBufferEnable   <= misoBufferEnableNext;
            DMWriteEnable      <= DMWriteEnableNext;
            busy               <= busyNext;
        end
    end

    // Next state, counter and Moore decode of the state being entered
    always_comb begin
        stateNext = state;
        countEdge = 1'b0;

        case (state)
            IDLE: begin
                if (!chipSelectConditioned) stateNext = GET_ADDR;
            end
            GET_ADDR: begin
                countEdge = sClkPosEdge;
                if (countEdge && (edgeCount == LAST_EDGE)) stateNext = GOT_ADDR;
            end
            GOT_ADDR: begin
                stateNext = readWriteEnable ? READ_LOAD : WRITE_SHIFT;
            end
            READ_LOAD: begin
                stateNext = READ_SHIFT;
            end
            READ_SHIFT: begin
                countEdge = sClkNegEdge;
                if (countEdge && (edgeCount == LAST_EDGE)) begin
`ifdef SPI_BURST_EN
                    stateNext = BURST_NEXT;
`else
                    stateNext = DONE;
`endif
                end
            end
            WRITE_SHIFT: begin
                countEdge = sClkPosEdge;
                if (countEdge && (edgeCount == LAST_EDGE)) stateNext = WRITE_COMMIT;
            end
            WRITE_COMMIT: begin
`ifdef SPI_BURST_EN
                stateNext = BURST_NEXT;
`else
                stateNext = DONE;
`endif
            end
            DONE: begin
                stateNext = DONE;
            end
            BURST_NEXT: begin
`ifdef SPI_BURST_EN
                stateNext = isRead ? READ_LOAD : WRITE_SHIFT;
`else
                stateNext = IDLE;
`endif
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Chip-select release ends any transaction, including a write still shifting
        if ((state != IDLE) && chipSelectConditioned) stateNext = IDLE;

        edgeCountNext = (stateNext != state) ? '0 : edgeCount + CNT_W'(countEdge);

        addressWriteEnableNext = (stateNext == GOT_ADDR);
        SRWriteEnableNext      = (stateNext == READ_LOAD);
        misoBufferEnableNext   = (stateNext == READ_SHIFT);
        DMWriteEnableNext      = (stateNext == WRITE_COMMIT);
        busyNext               = (stateNext != IDLE);
`ifdef SPI_BURST_EN
        addressIncrementNext   = (stateNext == BURST_NEXT);
`endif
    end

`ifdef SPI_BURST_EN
    // Direction is remembered so each burst byte re-enters the right data path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isRead           <= 1'b0;
            addressIncrement <= 1'b0;
        end else begin
            if (state == GOT_ADDR) isRead <= readWriteEnable;
            addressIncrement <= addressIncrementNext;
        end
    end
`else
    assign addressIncrement = 1'b0;
`endif

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Self-checking bench for spi_transaction_sequencer: per-cycle expected outputs built from
// transaction-level rules, plus literal pulse-count expectations.
module tb_spi_transaction_sequencer;

    localparam int unsigned B = 8;

    // Output vector order: {awe, srwe, miso, dmwe, inc, busy}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_BUSY = 6'b000001;
    localparam logic [5:0] O_AWE  = 6'b100001;
    localparam logic [5:0] O_SRWE = 6'b010001;
    localparam logic [5:0] O_MISO = 6'b001001;
    localparam logic [5:0] O_DMWE = 6'b000101;
    localparam logic [5:0] O_INC  = 6'b000011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic posIn = 1'b0;
    logic negIn = 1'b0;
    logic csIn = 1'b1;
    logic rwIn = 1'b0;
    logic awe, srwe, miso, dmwe, inc, busyOut;
    logic [5:0] dutOut;
    assign dutOut = {awe, srwe, miso, dmwe, inc, busyOut};

    bit burstMode;
    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int aweCount = 0, srweCount = 0, misoCount = 0, dmweCount = 0, incCount = 0;
    string phase = "init";
    logic [5:0] expQ[$];
    logic [5:0] expNow;

    spi_transaction_sequencer #(.BYTE_BITS(B)) dut (
        .clk                  (clk),
        .reset                (reset),
        .sClkPosEdge          (posIn),
        .sClkNegEdge          (negIn),
        .chipSelectConditioned(csIn),
        .readWriteEnable      (rwIn),
        .addressWriteEnable   (awe),
        .SRWriteEnable        (srwe),
        .misoBufferEnable     (miso),
        .DMWriteEnable        (dmwe),
        .addressIncrement     (inc),
        .busy                 (busyOut)
    );

    always #5 clk = ~clk;

    initial begin
`ifdef SPI_BURST_EN
        burstMode = 1'b1;
`else
        burstMode = 1'b0;
`endif
    end

    // Compare process: one check per driven cycle, just after the active edge
    always begin
        @(posedge clk);
        #1;
        cycle++;
        if (expQ.size() > 0) begin
            expNow = expQ.pop_front();
            checks++;
            if (dutOut !== expNow) begin
                errors++;
                $display("FAIL %s cycle %0d: {awe,srwe,miso,dmwe,inc,busy} got %b expected %b",
                         phase, cycle, dutOut, expNow);
            end
            aweCount  += int'(dutOut[5]);
            srweCount += int'(dutOut[4]);
            misoCount += int'(dutOut[3]);
            dmweCount += int'(dutOut[2]);
            incCount  += int'(dutOut[1]);
        end
    end

    task automatic checkLit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Drive one clk of inputs and record what the outputs must be after that edge
    task automatic tick(input logic cs, input logic pos, input logic neg, input logic rw,
                        input logic [5:0] e);
        @(negedge clk);
        csIn  = cs;
        posIn = pos;
        negIn = neg;
        rwIn  = rw;
        expQ.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // CS low, then B address posedges; stray negedges are ignored while collecting the address
    task automatic addrPhase(input logic rw, input int gap);
        tick(1'b0, 1'b0, 1'b0, rw, O_BUSY);
        for (int i = 0; i < int'(B); i++) begin
            tick(1'b0, 1'b1, (i % 3) == 1, rw, (i == int'(B) - 1) ? O_AWE : O_BUSY);
            if (i < int'(B) - 1) repeat (gap) tick(1'b0, 1'b0, 1'b1, rw, O_BUSY);
        end
    endtask

    task automatic readBytes(input int nEdges, input int gap);
        bit live = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1, O_SRWE);
        tick(1'b0, 1'b0, 1'b0, 1'b1, O_MISO);
        for (int e = 0; e < nEdges; e++) begin
            if (!live) begin
                tick(1'b0, 1'b0, 1'b1, 1'b1, O_BUSY);
            end else if ((e % int'(B)) == int'(B) - 1) begin
                if (burstMode) begin
                    tick(1'b0, (e % 2) == 1, 1'b1, 1'b1, O_INC);
                    tick(1'b0, 1'b0, 1'b0, 1'b1, O_SRWE);
                    tick(1'b0, 1'b0, 1'b0, 1'b1, O_MISO);
                end else begin
                    tick(1'b0, (e % 2) == 1, 1'b1, 1'b1, O_BUSY);
                    live = 1'b0;
                end
            end else begin
                tick(1'b0, (e % 2) == 1, 1'b1, 1'b1, O_MISO);
                repeat (gap) tick(1'b0, 1'b1, 1'b0, 1'b1, O_MISO);
            end
        end
    endtask

    task automatic writeBytes(input int nEdges, input int abortAt, input int gap);
        bit live = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY);
        for (int e = 0; e < nEdges; e++) begin
            if (e == abortAt) begin
                tick(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
                return;
            end
            if (!live) begin
                tick(1'b0, 1'b1, 1'b0, 1'b0, O_BUSY);
            end else if ((e % int'(B)) == int'(B) - 1) begin
                tick(1'b0, 1'b1, (e % 2) == 1, 1'b0, O_DMWE);
                if (burstMode) begin
                    tick(1'b0, 1'b0, 1'b0, 1'b0, O_INC);
                    tick(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY);
                end else begin
                    tick(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY);
                    live = 1'b0;
                end
            end else begin
                tick(1'b0, 1'b1, (e % 2) == 1, 1'b0, O_BUSY);
                repeat (gap) tick(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
            end
        end
    endtask

    task automatic endXfer(input int hold, input logic pulses, input logic [5:0] holdExp);
        repeat (hold) tick(1'b0, pulses, pulses, 1'b0, holdExp);
        tick(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
        tick(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, s0, m0, d0, i0;

        phase = "reset";
        #3;
        checkLit("reset_outputs", int'(dutOut), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
        tick(1'b1, 1'b0, 1'b0, 1'b0, O_IDLE);
        reset = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 1'b0, O_IDLE);

        phase = "read";
        addrPhase(1'b1, 1);
        readBytes(int'(B), 1);
        checkLit("read_awe_pulses", aweCount, 1);
        checkLit("read_srwe_pulses", srweCount, 1);
        checkLit("read_miso_cycles", misoCount, 15);
        endXfer(3, 1'b1, O_BUSY);

        phase = "write";
        addrPhase(1'b0, 0);
        writeBytes(int'(B), -1, 2);
        checkLit("write_dmwe_pulses", dmweCount, 1);
        checkLit("write_awe_pulses", aweCount, 2);
        endXfer(2, 1'b1, O_BUSY);

        phase = "abort_write";
        addrPhase(1'b0, 2);
        writeBytes(int'(B), 5, 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, O_IDLE);
        checkLit("abort_dmwe_pulses", dmweCount, 1);

        phase = "abort_addr";
        tick(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY);
        tick(1'b0, 1'b1, 1'b0, 1'b0, O_BUSY);
        tick(1'b1, 1'b1, 1'b0, 1'b0, O_IDLE);

        phase = "mid_reset";
        tick(1'b0, 1'b0, 1'b0, 1'b1, O_BUSY);
        tick(1'b0, 1'b1, 1'b0, 1'b1, O_BUSY);
        tick(1'b0, 1'b1, 1'b0, 1'b1, O_BUSY);
        @(negedge clk);
        csIn = 1'b0;
        posIn = 1'b1;
        expQ.push_back(O_IDLE);
        #2 reset = 1'b1;
        #1 checkLit("async_reset_outputs", int'(dutOut), 0);
        @(posedge clk);
        #2;
        tick(1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);
        reset = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);

        phase = "read_after_reset";
        a0 = aweCount;
        s0 = srweCount;
        addrPhase(1'b1, 0);
        readBytes(int'(B), 0);
        checkLit("post_reset_awe", aweCount - a0, 1);
        checkLit("post_reset_srwe", srweCount - s0, 1);
        endXfer(1, 1'b0, O_BUSY);

        phase = "burst_read";
        addrPhase(1'b1, 0);
        m0 = misoCount;
        i0 = incCount;
        readBytes(3 * int'(B), 0);
        checkLit("burst_read_inc", incCount - i0, burstMode ? 3 : 0);
        checkLit("burst_read_miso_cycles", misoCount - m0, burstMode ? 25 : 8);
        endXfer(2, 1'b0, burstMode ? O_MISO : O_BUSY);

        phase = "burst_write";
        d0 = dmweCount;
        i0 = incCount;
        addrPhase(1'b0, 0);
        writeBytes(2 * int'(B), -1, 0);
        checkLit("burst_write_dmwe", dmweCount - d0, burstMode ? 2 : 1);
        checkLit("burst_write_inc", incCount - i0, burstMode ? 2 : 0);
        endXfer(1, 1'b0, O_BUSY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
